inst_memory: RTL and testbench

- Pipeline memory-access stage; sits directly upstream of the writeback stage.
- Consumes execute-stage results (pc, instruction, destination register, ALU value, store data).
- Performs MIPS loads and stores through a req/ack data-memory port. Stalls upstream while an access is pending.
- Produces registered pc/inst/rd/rd_val for writeback, where rd==0 means no register write.

---
 rtl/mips_pkg.sv | 66 ++++++
 rtl/mem_lane_align.sv | 68 ++++++
 rtl/inst_memory.sv | 220 ++++++++++++++++++++++
 tb/tb_inst_memory.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg -- definitions shared by the memory-access stage and its helpers.
//
// Contents:
//   OP_LB .. OP_SW     MIPS load/store primary opcodes (inst[31:26])
//   stage_state_t      memory-stage state encoding (ST_IDLE, ST_ACCESS)
//   mem_size_t         access width (byte / half / word)
//   BE_* constants     big-endian byte-lane select patterns (be[3] = offset 0)
//   mem_op_t           decoded memory-op attributes
//   decode_mem_op()    opcode -> mem_op_t
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } stage_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  // Lane patterns. Byte offset 0 is the most significant lane (be[3]).
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b1000;  // shifted right by the byte offset
  localparam logic [3:0] BE_HALF_HI = 4'b1100;  // half at offset 0
  localparam logic [3:0] BE_HALF_LO = 4'b0011;  // half at offset 2
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef struct packed {
    logic      is_mem;
    logic      is_store;
    logic      is_signed;
    mem_size_t size;
  } mem_op_t;

  function automatic mem_op_t decode_mem_op(input logic [5:0] opcode);
    mem_op_t d;
    d.is_mem    = 1'b1;
    d.is_store  = 1'b0;
    d.is_signed = 1'b0;
    d.size      = SZ_WORD;
    case (opcode)
      OP_LB:  begin d.size = SZ_BYTE; d.is_signed = 1'b1; end
      OP_LH:  begin d.size = SZ_HALF; d.is_signed = 1'b1; end
      OP_LW:  d.size = SZ_WORD;
      OP_LBU: d.size = SZ_BYTE;
      OP_LHU: d.size = SZ_HALF;
      OP_SB:  begin d.size = SZ_BYTE; d.is_store = 1'b1; end
      OP_SH:  begin d.size = SZ_HALF; d.is_store = 1'b1; end
      OP_SW:  begin d.size = SZ_WORD; d.is_store = 1'b1; end
      default: d.is_mem = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align -- combinational byte-lane handling for the memory stage.
//
// Load side (uses the attributes latched for the access in flight):
//   ld_size, ld_signed, ld_off, mem_din  ->  load_val (aligned, sign/zero extended)
// Access side (uses the incoming instruction):
//   acc_size, acc_off, store_val  ->  acc_be, acc_dout (lane-replicated), acc_misaligned
// Lanes are big-endian: byte offset 0 lives in mem_din[31:24] and be[3].
module mem_lane_align
  import mips_pkg::*;
(
  input  mem_size_t   ld_size,
  input  logic        ld_signed,
  input  logic [1:0]  ld_off,
  input  logic [31:0] mem_din,
  output logic [31:0] load_val,
  input  mem_size_t   acc_size,
  input  logic [1:0]  acc_off,
  input  logic [31:0] store_val,
  output logic [3:0]  acc_be,
  output logic [31:0] acc_dout,
  output logic        acc_misaligned
);

  // din_lane[k] is the byte in physical lane k (lane 3 = MSB = offset 0).
  logic [7:0] din_lane [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign din_lane[gi] = mem_din[8*gi+7 -: 8];
    end
  endgenerate

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = din_lane[2'd3 - ld_off];
    ld_half = ld_off[1] ? mem_din[15:0] : mem_din[31:16];
    case (ld_size)
      SZ_BYTE: load_val = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_val = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: load_val = mem_din;
    endcase
  end

  always_comb begin
    acc_be         = BE_NONE;
    acc_dout       = store_val;
    acc_misaligned = 1'b0;
    case (acc_size)
      SZ_BYTE: begin
        acc_be   = BE_BYTE0 >> acc_off;
        acc_dout = {4{store_val[7:0]}};
      end
      SZ_HALF: begin
        acc_misaligned = acc_off[0];
        acc_be         = acc_off[1] ? BE_HALF_LO : BE_HALF_HI;
        acc_dout       = {2{store_val[15:0]}};
      end
      default: begin
        acc_misaligned = |acc_off;
        acc_be         = BE_WORD;
      end
    endcase
  end

endmodule

// File: rtl/inst_memory.sv
// inst_memory -- MIPS pipeline memory-access stage (feeds writeback).
//
// Non-memory instructions pass through with one cycle of latency. Loads and
// stores are latched and issued on a req/ack data-memory port; upstream is
// stalled until the ack arrives, then the result is registered for writeback.
// Misaligned halves/words issue no access and retire as a bubble (rd_out=0)
// with pc/inst still passed through.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   in_valid, pc_in, inst,   execute-stage result (pc is a word address [31:2])
//   rd, alu_val, store_val
//   stall                    upstream must hold its inputs while 1
//   mem_req, mem_we,         data-memory request (word address, big-endian
//   mem_addr, mem_be,        byte enables, lane-replicated store data)
//   mem_dout
//   mem_din, mem_ack         load data / completion
//   pc_out, inst_out,        registered writeback bundle; rd_out=0 means no write
//   rd_out, rd_val_out
//   addr_exc                 misaligned-access pulse
//
// Build option: define INST_MEMORY_ALIGN_TRAP_EN to make addr_exc pulse for one
// cycle alongside a misaligned instruction's writeback; otherwise it is tied 0.
module inst_memory
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [29:0]       pc_in,
  input  logic [31:0]       inst,
  input  logic [4:0]        rd,
  input  logic [31:0]       alu_val,
  input  logic [31:0]       store_val,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_dout,
  input  logic [31:0]       mem_din,
  input  logic              mem_ack,
  output logic [29:0]       pc_out,
  output logic [31:0]       inst_out,
  output logic [4:0]        rd_out,
  output logic [31:0]       rd_val_out,
  output logic              addr_exc
);

  stage_state_t state_reg, state_next;
  mem_op_t      in_op;

  // Access latched at acceptance; drives the memory port for the whole ACCESS.
  logic              lat_we_reg;
  logic              lat_signed_reg;
  mem_size_t         lat_size_reg;
  logic [1:0]        lat_off_reg;
  logic [ADDR_W-3:0] lat_addr_reg;
  logic [3:0]        lat_be_reg;
  logic [31:0]       lat_dout_reg;
  logic [29:0]       lat_pc_reg;
  logic [31:0]       lat_inst_reg;
  logic [4:0]        lat_rd_reg;

  logic [3:0]  acc_be;
  logic [31:0] acc_dout;
  logic        acc_misaligned;
  logic [31:0] load_val;
  logic        accept_mem;

  logic [29:0] pc_next;
  logic [31:0] inst_next;
  logic [4:0]  rd_next;
  logic [31:0] rd_val_next;

  assign in_op = decode_mem_op(inst[31:26]);

  mem_lane_align u_align (
    .ld_size        (lat_size_reg),
    .ld_signed      (lat_signed_reg),
    .ld_off         (lat_off_reg),
    .mem_din        (mem_din),
    .load_val       (load_val),
    .acc_size       (in_op.size),
    .acc_off        (alu_val[1:0]),
    .store_val      (store_val),
    .acc_be         (acc_be),
    .acc_dout       (acc_dout),
    .acc_misaligned (acc_misaligned)
  );

  assign accept_mem = (state_reg == ST_IDLE) & in_valid & in_op.is_mem & ~acc_misaligned;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept_mem) state_next = ST_ACCESS;
      ST_ACCESS: if (mem_ack)    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Anything not explicitly retiring writes a bubble (all zero) to writeback,
  // including the acceptance cycle of a memory op and each ACCESS wait cycle.
  always_comb begin
    stall       = 1'b0;
    mem_req     = 1'b0;
    pc_next     = '0;
    inst_next   = '0;
    rd_next     = '0;
    rd_val_next = '0;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid && !in_op.is_mem) begin
          pc_next     = pc_in;
          inst_next   = inst;
          rd_next     = rd;
          rd_val_next = alu_val;
        end else if (in_valid && acc_misaligned) begin
          // Misaligned: no access, retire as a bubble that still carries pc/inst.
          pc_next   = pc_in;
          inst_next = inst;
        end
      end
      ST_ACCESS: begin
        mem_req = 1'b1;
        stall   = ~mem_ack;
        if (mem_ack) begin
          pc_next   = lat_pc_reg;
          inst_next = lat_inst_reg;
          if (!lat_we_reg) begin
            rd_next     = lat_rd_reg;
            rd_val_next = load_val;
          end
        end
      end
      default: ;
    endcase
  end

  assign mem_we   = mem_req & lat_we_reg;
  assign mem_addr = lat_addr_reg;
  assign mem_be   = lat_be_reg;
  assign mem_dout = lat_dout_reg;

  // ---------------------------------------------------------------- access latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we_reg     <= 1'b0;
      lat_signed_reg <= 1'b0;
      lat_size_reg   <= SZ_WORD;
      lat_off_reg    <= '0;
      lat_addr_reg   <= '0;
      lat_be_reg     <= '0;
      lat_dout_reg   <= '0;
      lat_pc_reg     <= '0;
      lat_inst_reg   <= '0;
      lat_rd_reg     <= '0;
    end else if (accept_mem) begin
      lat_we_reg     <= in_op.is_store;
      lat_signed_reg <= in_op.is_signed;
      lat_size_reg   <= in_op.size;
      lat_off_reg    <= alu_val[1:0];
      lat_addr_reg   <= alu_val[ADDR_W-1:2];
      lat_be_reg     <= acc_be;
      lat_dout_reg   <= acc_dout;
      lat_pc_reg     <= pc_in;
      lat_inst_reg   <= inst;
      lat_rd_reg     <= rd;
    end
  end

  // ---------------------------------------------------------------- writeback registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out     <= '0;
      inst_out   <= '0;
      rd_out     <= '0;
      rd_val_out <= '0;
    end else begin
      pc_out     <= pc_next;
      inst_out   <= inst_next;
      rd_out     <= rd_next;
      rd_val_out <= rd_val_next;
    end
  end

`ifdef INST_MEMORY_ALIGN_TRAP_EN
  logic addr_exc_reg;
  logic addr_exc_next;

  assign addr_exc_next = (state_reg == ST_IDLE) & in_valid & in_op.is_mem & acc_misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_exc_reg <= 1'b0;
    end else begin
      addr_exc_reg <= addr_exc_next;
    end
  end

  assign addr_exc = addr_exc_reg;
`else
  assign addr_exc = 1'b0;
`endif

endmodule

// File: tb/tb_inst_memory.sv
// tb_inst_memory -- directed, table-driven bench for the memory-access stage.
module tb_inst_memory;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [29:0] pc_in;
  logic [31:0] inst;
  logic [4:0]  rd;
  logic [31:0] alu_val;
  logic [31:0] store_val;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_ack;
  logic [29:0] pc_out;
  logic [31:0] inst_out;
  logic [4:0]  rd_out;
  logic [31:0] rd_val_out;
  logic        addr_exc;

`ifdef INST_MEMORY_ALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  inst_memory #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .pc_in      (pc_in),
    .inst       (inst),
    .rd         (rd),
    .alu_val    (alu_val),
    .store_val  (store_val),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .mem_ack    (mem_ack),
    .pc_out     (pc_out),
    .inst_out   (inst_out),
    .rd_out     (rd_out),
    .rd_val_out (rd_val_out),
    .addr_exc   (addr_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] alu_val;
    logic [31:0] store_val;
    logic [31:0] din;
    logic [29:0] pc;
    bit          exp_access;
    logic [3:0]  exp_be;
    logic [31:0] exp_dout;
    bit          exp_we;
    logic [4:0]  exp_rd;
    bit          chk_val;
    logic [31:0] exp_val;
    bit          exp_exc;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] r, input logic [31:0] a,
                              input logic [31:0] sv, input logic [31:0] d, input logic [29:0] p,
                              input bit acc, input logic [3:0] be, input logic [31:0] dout,
                              input bit we, input logic [4:0] erd, input bit cv,
                              input logic [31:0] ev, input bit exc);
    vec_t v;
    v.inst = {op, 5'd4, 5'd5, r, 11'h021};
    v.rd = r; v.alu_val = a; v.store_val = sv; v.din = d; v.pc = p;
    v.exp_access = acc; v.exp_be = be; v.exp_dout = dout; v.exp_we = we;
    v.exp_rd = erd; v.chk_val = cv; v.exp_val = ev; v.exp_exc = exc;
    return v;
  endfunction

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic clear_inputs();
    in_valid = 1'b0; pc_in = '0; inst = '0; rd = '0;
    alu_val = '0; store_val = '0; mem_din = '0; mem_ack = 1'b0;
  endtask

  task automatic present(input logic [31:0] i, input logic [4:0] r, input logic [31:0] a,
                         input logic [31:0] sv, input logic [29:0] p);
    in_valid = 1'b1; inst = i; rd = r; alu_val = a; store_val = sv; pc_in = p;
  endtask

  int stall_cnt;

  initial begin
    // op  rd   alu_val        store_val      din            pc        acc be       dout           we erd  cv  val            exc
    vecs[0]  = mk(6'h00, 5'd5, 32'h0000_1234, 32'h0,         32'h0,         30'h10, 0, 4'b0000, 32'h0,         0, 5'd5, 1, 32'h0000_1234, 0);
    vecs[1]  = mk(6'h20, 5'd7, 32'h0000_0201, 32'h0,         32'h0080_0000, 30'h11, 1, 4'b0100, 32'h0,         0, 5'd7, 1, 32'hFFFF_FF80, 0);
    vecs[2]  = mk(6'h24, 5'd7, 32'h0000_0201, 32'h0,         32'h0080_0000, 30'h12, 1, 4'b0100, 32'h0,         0, 5'd7, 1, 32'h0000_0080, 0);
    vecs[3]  = mk(6'h29, 5'd9, 32'h0000_0302, 32'hAAAA_5555, 32'h0,         30'h13, 1, 4'b0011, 32'h5555_5555, 1, 5'd0, 1, 32'h0,         0);
    vecs[4]  = mk(6'h21, 5'd8, 32'h0000_0400, 32'h0,         32'h8001_1234, 30'h14, 1, 4'b1100, 32'h0,         0, 5'd8, 1, 32'hFFFF_8001, 0);
    vecs[5]  = mk(6'h25, 5'd8, 32'h0000_0402, 32'h0,         32'h1234_F00D, 30'h15, 1, 4'b0011, 32'h0,         0, 5'd8, 1, 32'h0000_F00D, 0);
    vecs[6]  = mk(6'h28, 5'd2, 32'h0000_0503, 32'h1234_5678, 32'h0,         30'h16, 1, 4'b0001, 32'h7878_7878, 1, 5'd0, 1, 32'h0,         0);
    vecs[7]  = mk(6'h2B, 5'd2, 32'h0000_0600, 32'hCAFE_F00D, 32'h0,         30'h17, 1, 4'b1111, 32'hCAFE_F00D, 1, 5'd0, 1, 32'h0,         0);
    vecs[8]  = mk(6'h23, 5'd3, 32'h0000_0102, 32'h0,         32'h0,         30'h18, 0, 4'b0000, 32'h0,         0, 5'd0, 1, 32'h0,         1);
    vecs[9]  = mk(6'h21, 5'd3, 32'h0000_0101, 32'h0,         32'h0,         30'h19, 0, 4'b0000, 32'h0,         0, 5'd0, 1, 32'h0,         1);
    vecs[10] = mk(6'h23, 5'd0, 32'h0000_0700, 32'h0,         32'h1111_1111, 30'h1A, 1, 4'b1111, 32'h0,         0, 5'd0, 0, 32'h0,         0);
    vecs[11] = mk(6'h0D, 5'd3, 32'hFFFF_0000, 32'h0,         32'h0,         30'h1B, 0, 4'b0000, 32'h0,         0, 5'd3, 1, 32'hFFFF_0000, 0);
    vecs[12] = mk(6'h20, 5'd1, 32'h0000_0803, 32'h0,         32'h0000_00FF, 30'h1C, 1, 4'b0001, 32'h0,         0, 5'd1, 1, 32'hFFFF_FFFF, 0);

    clear_inputs();
    rst = 1'b1;
    #12;
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_pc_out", {2'b0, pc_out}, 32'h0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_rd_out", {27'b0, rd_out}, 32'h0);
    chk("rst_rd_val_out", rd_val_out, 32'h0);
    chk("rst_addr_exc", {31'b0, addr_exc}, 32'h0);
    step();
    rst = 1'b0;
    step();

    // ---------------- table-driven single-op vectors (ack in first ACCESS cycle)
    for (int i = 0; i < NV; i++) begin
      present(vecs[i].inst, vecs[i].rd, vecs[i].alu_val, vecs[i].store_val, vecs[i].pc);
      #1;
      chk($sformatf("v%0d_stall_idle", i), {31'b0, stall}, 32'h0);
      step();
      in_valid = 1'b0;
      if (vecs[i].exp_access) begin
        chk($sformatf("v%0d_mem_req", i), {31'b0, mem_req}, 32'h1);
        chk($sformatf("v%0d_mem_addr", i), {2'b0, mem_addr}, {2'b0, vecs[i].alu_val[31:2]});
        chk($sformatf("v%0d_mem_be", i), {28'b0, mem_be}, {28'b0, vecs[i].exp_be});
        chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].exp_we});
        if (vecs[i].exp_we) chk($sformatf("v%0d_mem_dout", i), mem_dout, vecs[i].exp_dout);
        chk($sformatf("v%0d_accept_bubble", i), {27'b0, rd_out}, 32'h0);
        mem_ack = 1'b1;
        mem_din = vecs[i].din;
        #1;
        chk($sformatf("v%0d_stall_ack", i), {31'b0, stall}, 32'h0);
        step();
        mem_ack = 1'b0;
      end else begin
        chk($sformatf("v%0d_no_req", i), {31'b0, mem_req}, 32'h0);
      end
      chk($sformatf("v%0d_pc_out", i), {2'b0, pc_out}, {2'b0, vecs[i].pc});
      chk($sformatf("v%0d_inst_out", i), inst_out, vecs[i].inst);
      chk($sformatf("v%0d_rd_out", i), {27'b0, rd_out}, {27'b0, vecs[i].exp_rd});
      if (vecs[i].chk_val) chk($sformatf("v%0d_rd_val_out", i), rd_val_out, vecs[i].exp_val);
      chk($sformatf("v%0d_addr_exc", i), {31'b0, addr_exc}, {31'b0, vecs[i].exp_exc & TRAP_EN});
      $display("vec %0d: inst=0x%08h alu=0x%08h -> rd_out=%0d rd_val_out=0x%08h", i, vecs[i].inst,
               vecs[i].alu_val, rd_out, rd_val_out);
      step();
    end

    // ---------------- addr_exc is a single-cycle pulse
    present({6'h23, 26'h0}, 5'd3, 32'h0000_0106, 32'h0, 30'h30);
    step();
    in_valid = 1'b0;
    chk("exc_pulse_hi", {31'b0, addr_exc}, {31'b0, TRAP_EN});
    step();
    chk("exc_pulse_lo", {31'b0, addr_exc}, 32'h0);
    $display("seq exc_pulse: addr_exc now %0b", addr_exc);

    // ---------------- LW with three wait cycles, addu presented during the ack cycle
    present({6'h23, 26'h0}, 5'd6, 32'h0000_0100, 32'h0, 30'h40);
    step();
    in_valid = 1'b0;
    stall_cnt = 0;
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("lw_wait%0d_req", w), {31'b0, mem_req}, 32'h1);
      chk($sformatf("lw_wait%0d_addr", w), {2'b0, mem_addr}, 32'h0000_0040);
      chk($sformatf("lw_wait%0d_be", w), {28'b0, mem_be}, 32'h0000_000F);
      if (stall) stall_cnt++;
      step();
      chk($sformatf("lw_wait%0d_bubble", w), {27'b0, rd_out}, 32'h0);
    end
    present(32'h0085_2021, 5'd4, 32'h0000_0055, 32'h0, 30'h41);
    mem_ack = 1'b1;
    mem_din = 32'hDEAD_BEEF;
    #1;
    if (stall) stall_cnt++;
    chk("lw_stall_cycles", stall_cnt, 32'd3);
    step();
    mem_ack = 1'b0;
    chk("lw_rd_out", {27'b0, rd_out}, 32'd6);
    chk("lw_rd_val_out", rd_val_out, 32'hDEAD_BEEF);
    chk("lw_pc_out", {2'b0, pc_out}, 32'h0000_0040);
    chk("lw_back_idle", {31'b0, mem_req}, 32'h0);
    $display("seq lw_wait: stall cycles=%0d rd_val_out=0x%08h", stall_cnt, rd_val_out);
    step();
    in_valid = 1'b0;
    chk("post_ack_addu_rd", {27'b0, rd_out}, 32'd4);
    chk("post_ack_addu_val", rd_val_out, 32'h0000_0055);
    chk("post_ack_addu_pc", {2'b0, pc_out}, 32'h0000_0041);
    $display("seq post_ack: rd_out=%0d rd_val_out=0x%08h", rd_out, rd_val_out);
    step();
    chk("idle_bubble_rd", {27'b0, rd_out}, 32'h0);
    chk("idle_bubble_pc", {2'b0, pc_out}, 32'h0);

    // ---------------- reset in the middle of an access
    present(32'h0085_2021, 5'd12, 32'h0000_0077, 32'h0, 30'h50);
    step();
    present({6'h23, 26'h0}, 5'd6, 32'h0000_0200, 32'h0, 30'h51);
    step();
    in_valid = 1'b0;
    chk("mid_pre_req", {31'b0, mem_req}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'b0, mem_req}, 32'h0);
    chk("mid_rst_stall", {31'b0, stall}, 32'h0);
    chk("mid_rst_rd_out", {27'b0, rd_out}, 32'h0);
    chk("mid_rst_pc_out", {2'b0, pc_out}, 32'h0);
    step();
    rst = 1'b0;
    mem_ack = 1'b1;  // stale ack after reset must not produce a writeback
    step();
    mem_ack = 1'b0;
    chk("mid_after_rd_out", {27'b0, rd_out}, 32'h0);
    present(32'h0085_2021, 5'd5, 32'h0000_1234, 32'h0, 30'h60);
    #1;
    chk("mid_after_stall", {31'b0, stall}, 32'h0);
    step();
    in_valid = 1'b0;
    chk("mid_after_addu_rd", {27'b0, rd_out}, 32'd5);
    chk("mid_after_addu_val", rd_val_out, 32'h0000_1234);
    $display("seq reset_mid_access: rd_out=%0d rd_val_out=0x%08h", rd_out, rd_val_out);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time bound so the run always ends even if stimulus is mis-sequenced.
  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
